// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer and the downstream ones-counter stage.
package serializer_pkg;

    // Serializer FSM state encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Default word width and inter-frame gap, shared with the ones counter.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 1;

    // Width of the inter-frame gap counter (GAP range 0..15).
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter: accepts a word over valid/ready and emits it
// MSB-first, one bit per cycle, with bit valid, frame start and frame end strobes.
// bit_out is held low whenever no data bit is presented, so a level-sensitive
// ones counter downstream only ever sees real data.
module bit_stream_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int                    CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0]  GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;
    localparam bit                    HAS_GAP  = (GAP > 0);

    state_e                 state_q;
    logic [WIDTH-1:0]       shreg_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_q;
    logic                   bit_out_q;
    logic                   bit_valid_q;
    logic                   frame_start_q;
    logic                   frame_end_q;
    logic                   busy_q;

    logic                   ready;
    logic                   accept;

    // Ready decode: idle, or the last bit of a frame when frames run back-to-back.
    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE:  ready = 1'b1;
                ST_SHIFT: ready = !HAS_GAP && (bit_cnt_q == '0);
                default:  ready = 1'b0;
            endcase
        end
    end

    assign accept    = din_valid && ready;
    assign din_ready = ready;

    // Serializer FSM: shift register, bit and gap counters, and the registered
    // output strobes, which are loaded with the values for the coming cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q       <= ST_SHIFT;
                        shreg_q       <= din;
                        bit_cnt_q     <= LAST_BIT;
                        bit_out_q     <= din[WIDTH-1];
                        bit_valid_q   <= 1'b1;
                        frame_start_q <= 1'b1;
                        frame_end_q   <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        // Mid-frame: present the next lower bit.
                        shreg_q       <= shreg_q << 1;
                        bit_cnt_q     <= bit_cnt_q - 1'b1;
                        bit_out_q     <= shreg_q[WIDTH-2];
                        frame_start_q <= 1'b0;
                        frame_end_q   <= (bit_cnt_q == CNT_W'(1));
                    end else if (HAS_GAP) begin
                        // Last bit done: insert the idle gap.
                        state_q       <= ST_GAP;
                        shreg_q       <= shreg_q << 1;
                        gap_cnt_q     <= GAP_LOAD;
                        bit_out_q     <= 1'b0;
                        bit_valid_q   <= 1'b0;
                        frame_start_q <= 1'b0;
                        frame_end_q   <= 1'b0;
                    end else if (accept) begin
                        // No gap and a word is waiting: start the next frame at once.
                        shreg_q       <= din;
                        bit_cnt_q     <= LAST_BIT;
                        bit_out_q     <= din[WIDTH-1];
                        frame_start_q <= 1'b1;
                        frame_end_q   <= 1'b0;
                    end else begin
                        state_q       <= ST_IDLE;
                        shreg_q       <= shreg_q << 1;
                        bit_out_q     <= 1'b0;
                        bit_valid_q   <= 1'b0;
                        frame_start_q <= 1'b0;
                        frame_end_q   <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q       <= ST_IDLE;
                    bit_out_q     <= 1'b0;
                    bit_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_end_q   <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: two instances (GAP=1 and GAP=0) share the
// same stimulus; a timeline model predicts every output cycle by cycle.
module tb_bit_stream_serializer;

    localparam int W    = 8;
    localparam int G0   = 1;
    localparam int G1   = 0;
    localparam int TL   = 4096;
    localparam int NREC = 32;

    typedef struct packed {
        logic busy;
        logic fe;
        logic fs;
        logic valid;
        logic data;
    } entry_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;

    logic rdy0, bo0, bv0, fs0, fe0, busy0;
    logic rdy1, bo1, bv1, fs1, fe1, busy1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    entry_t exp_tl [2][TL];
    entry_t rec0 [NREC];
    entry_t rec1 [NREC];
    logic   rrdy0 [NREC];
    logic   rrdy1 [NREC];

    bit_stream_serializer #(.WIDTH(W), .GAP(G0)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .bit_out(bo0), .bit_valid(bv0),
        .frame_start(fs0), .frame_end(fe0), .busy(busy0)
    );

    bit_stream_serializer #(.WIDTH(W), .GAP(G1)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .bit_out(bo1), .bit_valid(bv1),
        .frame_start(fs1), .frame_end(fe1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic entry_t sample(input int k);
        if (k == 0) return '{busy: busy0, fe: fe0, fs: fs0, valid: bv0, data: bo0};
        return '{busy: busy1, fe: fe1, fs: fs1, valid: bv1, data: bo1};
    endfunction

    // Drive one cycle's inputs, record both instances' outputs mid-cycle, advance.
    task automatic drive(input logic [W-1:0] d, input logic v, input int idx);
        din       = d;
        din_valid = v;
        @(negedge clk);
        if (idx >= 0 && idx < NREC) begin
            rec0[idx]  = sample(0);
            rec1[idx]  = sample(1);
            rrdy0[idx] = rdy0;
            rrdy1[idx] = rdy1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, -1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            entry_t e;
            e = sample(k);
            check({tag, "_bit_out"},     k, e.data,  0);
            check({tag, "_bit_valid"},   k, e.valid, 0);
            check({tag, "_frame_start"}, k, e.fs,    0);
            check({tag, "_frame_end"},   k, e.fe,    0);
            check({tag, "_busy"},        k, e.busy,  0);
            check({tag, "_din_ready"},   k, (k == 0) ? rdy0 : rdy1, 0);
        end
    endtask

    // Reference model: each accepted word writes its future per-cycle outputs
    // into a timeline; every cycle the DUT outputs are compared with it.
    initial begin : compare
        entry_t act_e, exp_e;
        logic   exp_rdy, act_rdy;
        int     gap_k;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < TL; j++) exp_tl[k][j] = '0;
        forever begin
            @(negedge clk);
            if (cyc < TL - 64) begin
                for (int k = 0; k < 2; k++) begin
                    gap_k   = (k == 0) ? G0 : G1;
                    act_e   = sample(k);
                    act_rdy = (k == 0) ? rdy0 : rdy1;
                    if (!rst_n) begin
                        exp_e   = '0;
                        exp_rdy = 1'b0;
                        for (int j = 0; j < W + 18; j++) exp_tl[k][cyc + j] = '0;
                    end else begin
                        exp_e   = exp_tl[k][cyc];
                        exp_rdy = !exp_e.busy || (gap_k == 0 && exp_e.fe);
                    end
                    check("bit_out",     k, act_e.data,  exp_e.data);
                    check("bit_valid",   k, act_e.valid, exp_e.valid);
                    check("frame_start", k, act_e.fs,    exp_e.fs);
                    check("frame_end",   k, act_e.fe,    exp_e.fe);
                    check("busy",        k, act_e.busy,  exp_e.busy);
                    check("din_ready",   k, act_rdy,     exp_rdy);
                    if (rst_n && din_valid && exp_rdy) begin
                        for (int i = 0; i < W; i++)
                            exp_tl[k][cyc + 1 + i] = '{busy: 1'b1, fe: (i == W - 1), fs: (i == 0),
                                                       valid: 1'b1, data: din[W - 1 - i]};
                        for (int g = 0; g < gap_k; g++)
                            exp_tl[k][cyc + 1 + W + g] = '{busy: 1'b1, fe: 1'b0, fs: 1'b0,
                                                           valid: 1'b0, data: 1'b0};
                    end
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [W-1:0] word;
        int           ones;
        int           nvalid;
        din       = '0;
        din_valid = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset held for three cycles: everything low, not ready.
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 0, rdy0, 1);
        check("ready_after_release", 1, rdy1, 1);
        @(posedge clk);
        #1;
        idle(4);
        check("no_valid_after_release", 0, bv0, 0);

        // 8'hA5 on the GAP=1 instance.
        drive(8'hA5, 1'b1, 0);
        for (int i = 1; i <= 12; i++) drive('0, 1'b0, i);
        word = '0; ones = 0; nvalid = 0;
        for (int i = 1; i <= 8; i++) begin
            word   = {word[W-2:0], rec0[i].data};
            ones   += int'(rec0[i].data);
            nvalid += int'(rec0[i].valid);
        end
        check("a5_accept_ready", 0, rrdy0[0], 1);
        check("a5_word", 0, word, 8'hA5);
        check("a5_ones", 0, ones, 4);
        check("a5_valid_cycles", 0, nvalid, 8);
        check("a5_frame_start_c1", 0, rec0[1].fs, 1);
        check("a5_frame_end_c8", 0, rec0[8].fe, 1);
        check("a5_c9_valid", 0, rec0[9].valid, 0);
        check("a5_c9_bit", 0, rec0[9].data, 0);
        check("a5_c9_ready", 0, rrdy0[9], 0);
        check("a5_c10_ready", 0, rrdy0[10], 1);
        idle(20);

        // 8'hFF then 8'h00 with din_valid held high.
        drive(8'hFF, 1'b1, 0);
        for (int i = 1; i <= 18; i++) drive(8'h00, 1'b1, i);
        din_valid = 1'b0;
        ones = 0;
        for (int i = 1; i <= 8; i++) ones += int'(rec0[i].data & rec0[i].valid);
        check("ff_ones", 0, ones, 8);
        check("ff_second_accept_c10", 0, rrdy0[10], 1);
        ones = 0; nvalid = 0;
        for (int i = 11; i <= 18; i++) begin
            ones   += int'(rec0[i].data);
            nvalid += int'(rec0[i].valid);
        end
        check("zero_word_ones", 0, ones, 0);
        check("zero_word_valid", 0, nvalid, 8);
        check("zero_word_start_c11", 0, rec0[11].fs, 1);
        idle(40);

        // Back-to-back 8'h81, 8'h7E on the GAP=0 instance.
        drive(8'h81, 1'b1, 0);
        for (int i = 1; i <= 7; i++) drive('0, 1'b0, i);
        drive(8'h7E, 1'b1, 8);
        for (int i = 9; i <= 17; i++) drive('0, 1'b0, i);
        ones = 0; nvalid = 0;
        for (int i = 1; i <= 16; i++) begin
            ones   += int'(rec1[i].data);
            nvalid += int'(rec1[i].valid);
        end
        check("b2b_ready_c8", 1, rrdy1[8], 1);
        check("b2b_valid_cycles", 1, nvalid, 16);
        check("b2b_ones", 1, ones, 8);
        check("b2b_frame_end_c8", 1, rec1[8].fe, 1);
        check("b2b_frame_start_c9", 1, rec1[9].fs, 1);
        check("b2b_c17_valid", 1, rec1[17].valid, 0);
        idle(20);

        // Asynchronous reset in cycle 4 of an 8'hF0 frame.
        drive(8'hF0, 1'b1, 0);
        for (int i = 1; i <= 3; i++) drive('0, 1'b0, i);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("ready_after_async_reset", 0, rdy0, 1);
        check("ready_after_async_reset", 1, rdy1, 1);
        for (int i = 0; i < 12; i++) drive('0, 1'b0, i);
        nvalid = 0;
        for (int i = 0; i < 12; i++) nvalid += int'(rec0[i].valid) + int'(rec1[i].valid);
        check("no_residual_bits", 0, nvalid, 0);

        // 8'hC3 with din changed to 8'h00 from cycle 2, din_valid high.
        drive(8'hC3, 1'b1, 0);
        drive(8'hC3, 1'b0, 1);
        for (int i = 2; i <= 9; i++) drive(8'h00, 1'b1, i);
        din_valid = 1'b0;
        word = '0;
        for (int i = 1; i <= 8; i++) word = {word[W-2:0], rec0[i].data};
        check("c3_word_held", 0, word, 8'hC3);
        idle(20);

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                drive(W'($urandom), ($urandom_range(0, 3) != 0), -1);
            end
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
